spu_nearest_point: RTL

- Parametrised successor to the fixed 4-bit Manhattan-distance unit in the Spatial Processing Unit.
- Latches a query point, then accepts a stream of candidate points over a valid/ready handshake.
- Emits a per-candidate distance in one of three metrics (Manhattan, Chebyshev, squared Euclidean).
- At end of stream, reports the nearest candidate's distance and stream index.

---
 rtl/spu_nearest_point_if.sv | 37 +++
 rtl/spu_nearest_point.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spu_nearest_point_if.sv
// Query/candidate/result bundle for the nearest-point unit.
// The master drives the query and the candidate stream; the slave returns the distances and the result.
interface spu_nearest_point_if #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned IDX_W   = 8
);
    localparam int unsigned DIST_W = 2 * COORD_W + 1;

    logic [1:0]         mode;
    logic               q_load;
    logic [COORD_W-1:0] q_x;
    logic [COORD_W-1:0] q_y;
    logic               pt_valid;
    logic               pt_ready;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic               pt_last;
    logic               dist_valid;
    logic [DIST_W-1:0]  dist_out;
    logic [IDX_W-1:0]   dist_idx;
    logic               res_valid;
    logic [DIST_W-1:0]  res_dist;
    logic [IDX_W-1:0]   res_idx;
    logic               busy;

    modport master (
        output mode, q_load, q_x, q_y, pt_valid, pt_x, pt_y, pt_last,
        input  pt_ready, dist_valid, dist_out, dist_idx,
               res_valid, res_dist, res_idx, busy
    );

    modport slave (
        input  mode, q_load, q_x, q_y, pt_valid, pt_x, pt_y, pt_last,
        output pt_ready, dist_valid, dist_out, dist_idx,
               res_valid, res_dist, res_idx, busy
    );
endinterface

// File: rtl/spu_nearest_point.sv
// Streams candidate points against a latched query point and reports each candidate's distance.
// At the end of the stream it reports the minimum distance and the index of that candidate.
module spu_nearest_point #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned IDX_W   = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    spu_nearest_point_if.slave  bus
);
    localparam int unsigned DIST_W = 2 * COORD_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_mode;
    logic [COORD_W-1:0] r_qx;
    logic [COORD_W-1:0] r_qy;
    logic [IDX_W-1:0]   r_idx;

    logic               r_s1_valid;
    logic [COORD_W-1:0] r_s1_dx;
    logic [COORD_W-1:0] r_s1_dy;
    logic [IDX_W-1:0]   r_s1_idx;

    logic [DIST_W-1:0]  r_best_dist;
    logic [IDX_W-1:0]   r_best_idx;

    logic               r_pt_ready;
    logic               r_busy;
    logic               r_dist_valid;
    logic [DIST_W-1:0]  r_dist_out;
    logic [IDX_W-1:0]   r_dist_idx;
    logic               r_res_valid;
    logic [DIST_W-1:0]  r_res_dist;
    logic [IDX_W-1:0]   r_res_idx;

    logic               w_hs;
    logic               w_load;
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [DIST_W-1:0]  w_dx_e;
    logic [DIST_W-1:0]  w_dy_e;
    logic [DIST_W-1:0]  w_dist;
    logic               w_better;
    logic [DIST_W-1:0]  w_best_dist_nxt;
    logic [IDX_W-1:0]   w_best_idx_nxt;

    // r_pt_ready is high exactly while the FSM sits in RUN
    assign w_hs   = bus.pt_valid & r_pt_ready;
    assign w_load = bus.q_load & (r_state == S_IDLE);

    assign w_dx = (bus.pt_x >= r_qx) ? (bus.pt_x - r_qx) : (r_qx - bus.pt_x);
    assign w_dy = (bus.pt_y >= r_qy) ? (bus.pt_y - r_qy) : (r_qy - bus.pt_y);

    assign w_dx_e = DIST_W'(r_s1_dx);
    assign w_dy_e = DIST_W'(r_s1_dy);

    // Metric selection; the unused encoding falls back to Manhattan
    always_comb begin
        w_dist = w_dx_e + w_dy_e;
        case (r_mode)
            2'b01:   w_dist = (w_dx_e >= w_dy_e) ? w_dx_e : w_dy_e;
            2'b10:   w_dist = (w_dx_e * w_dx_e) + (w_dy_e * w_dy_e);
            default: w_dist = w_dx_e + w_dy_e;
        endcase
    end

    // Strict compare keeps the earliest index on ties
    assign w_better        = r_s1_valid && (w_dist < r_best_dist);
    assign w_best_dist_nxt = w_better ? w_dist : r_best_dist;
    assign w_best_idx_nxt  = w_better ? r_s1_idx : r_best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_state_nxt = S_RUN;
            S_RUN:   if (w_hs && bus.pt_last) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= 2'b00;
            r_qx         <= '0;
            r_qy         <= '0;
            r_idx        <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_dx      <= '0;
            r_s1_dy      <= '0;
            r_s1_idx     <= '0;
            r_best_dist  <= '1;
            r_best_idx   <= '0;
            r_pt_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_dist_valid <= 1'b0;
            r_dist_out   <= '0;
            r_dist_idx   <= '0;
            r_res_valid  <= 1'b0;
            r_res_dist   <= '0;
            r_res_idx    <= '0;
        end else begin
            r_pt_ready  <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_res_valid <= (w_state_nxt == S_DONE);

            // Stage 1: absolute coordinate differences
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_dx  <= w_dx;
                r_s1_dy  <= w_dy;
                r_s1_idx <= r_idx;
                r_idx    <= r_idx + IDX_W'(1);
            end

            // Stage 2: distance output and running minimum
            r_dist_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dist_out <= w_dist;
                r_dist_idx <= r_s1_idx;
            end

            if (w_load) begin
                r_mode      <= bus.mode;
                r_qx        <= bus.q_x;
                r_qy        <= bus.q_y;
                r_idx       <= '0;
                r_best_dist <= '1;
                r_best_idx  <= '0;
                r_res_dist  <= '0;
                r_res_idx   <= '0;
            end else begin
                r_best_dist <= w_best_dist_nxt;
                r_best_idx  <= w_best_idx_nxt;
            end

            // The last candidate is in stage 2 during DRAIN, so fold it into the result here
            if (r_state == S_DRAIN) begin
                r_res_dist <= w_best_dist_nxt;
                r_res_idx  <= w_best_idx_nxt;
            end
        end
    end

    assign bus.pt_ready   = r_pt_ready;
    assign bus.busy       = r_busy;
    assign bus.dist_valid = r_dist_valid;
    assign bus.dist_out   = r_dist_out;
    assign bus.dist_idx   = r_dist_idx;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_dist   = r_res_dist;
    assign bus.res_idx    = r_res_idx;
endmodule
